// File: rtl/and_or_not_bist_ctrl.sv
// Built-in self-test sequencer for the andOrNot gate block: sweeps all eight
// {A,B,C} vectors, samples D/E after a settle time and accumulates the results.
module and_or_not_bist_ctrl #(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXP_D         = 8'hEA,
   parameter logic [7:0]  EXP_E         = 8'h55,
   parameter bit          STOP_ON_FAIL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       dut_d,
   input  logic       dut_e,
   output logic       tst_a,
   output logic       tst_b,
   output logic       tst_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [3:0] err_count
);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, FIN} state_t;

   // Settle counter is loaded with SETTLE_CYCLES-1 so APPLY spans exactly SETTLE_CYCLES cycles.
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] k_q, k_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] tst_q, tst_d;
   logic       busy_d, done_d, pass_d;
   logic [7:0] mask_d;
   logic [3:0] err_d;
   logic       mismatch;
   logic       last_vec;

   // Case inequality so an X/Z on the gate outputs is reported as a failure.
   always_comb begin
      mismatch = (dut_d !== EXP_D[k_q]) || (dut_e !== EXP_E[k_q]);
      last_vec = (k_q == 3'd7) || (STOP_ON_FAIL && mismatch);
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= 3'd0;
         cnt_q     <= 4'd0;
         tst_q     <= 3'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= 8'd0;
         err_count <= 4'd0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         tst_q     <= tst_d;
         busy      <= busy_d;
         done      <= done_d;
         pass      <= pass_d;
         fail_mask <= mask_d;
         err_count <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && !abort) state_d = APPLY;
         APPLY:   if (abort)                 state_d = IDLE;
                  else if (cnt_q == 4'd0)    state_d = CHECK;
         CHECK:   if (abort)                 state_d = IDLE;
                  else if (last_vec)         state_d = FIN;
                  else                       state_d = APPLY;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      k_d    = k_q;
      cnt_d  = cnt_q;
      tst_d  = 3'd0;
      busy_d = 1'b0;
      done_d = 1'b0;
      pass_d = pass;
      mask_d = fail_mask;
      err_d  = err_count;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               k_d    = 3'd0;
               cnt_d  = SETTLE_LD;
               mask_d = 8'd0;
               err_d  = 4'd0;
               pass_d = 1'b0;
               busy_d = 1'b1;
            end
         end
         APPLY: begin
            if (abort) begin
               k_d    = 3'd0;
               pass_d = 1'b0;
            end else begin
               busy_d = 1'b1;
               tst_d  = k_q;
               if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
         end
         CHECK: begin
            if (abort) begin
               k_d    = 3'd0;
               pass_d = 1'b0;
            end else begin
               if (mismatch) begin
                  mask_d[k_q] = 1'b1;
                  err_d       = err_count + 4'd1;
               end
               if (last_vec) begin
                  k_d    = 3'd0;
                  done_d = 1'b1;
                  pass_d = (err_d == 4'd0);
               end else begin
                  k_d    = k_q + 3'd1;
                  cnt_d  = SETTLE_LD;
                  busy_d = 1'b1;
                  tst_d  = k_q + 3'd1;
               end
            end
         end
         FIN:     k_d = 3'd0;
         default: k_d = 3'd0;
      endcase
   end

   assign tst_a = tst_q[2];
   assign tst_b = tst_q[1];
   assign tst_c = tst_q[0];

endmodule
